// File: rtl/hazard_pkg.sv
// hazard_pkg: stage-control encodings and hold FSM state type shared by the hazard controller. Rev 1.0
`default_nettype none

package hazard_pkg;

  localparam logic [1:0] RUN   = 2'b00;
  localparam logic [1:0] STALL = 2'b01;
  localparam logic [1:0] FLUSH = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hold_state_t;

  // Counter width with a 1-bit floor, so a zero-length hold still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/csr_flush_seq.sv
// csr_flush_seq: after a CSR flush pulse, holds the front end for FLUSH_HOLD_CYCLES further cycles. Rev 1.0
`default_nettype none

module csr_flush_seq
  import hazard_pkg::*;
#(
  parameter int unsigned FLUSH_HOLD_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic csr_flush_i,
  output logic csr_hold_o
);

  localparam int unsigned     CNT_W     = cnt_width(FLUSH_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(FLUSH_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  hold_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A new pulse always restarts the count; leaving HOLD coincides with the count reaching zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (FLUSH_HOLD_CYCLES == 0) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (csr_flush_i) begin
      state_nxt = HOLD;
      cnt_nxt   = HOLD_LOAD;
    end else if (state == HOLD) begin
      if (cnt <= CNT_ONE) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt - CNT_ONE;
      end
    end
  end

  always_comb begin
    csr_hold_o = !rst_i && (csr_flush_i || (state == HOLD));
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: per-stage stall/flush priority with redirect ack and CSR front-end hold.
// Optional HAZARD_PERF_CNT_EN adds saturating stall-cycle and flush-event counters. Rev 1.0
`default_nettype none

module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_STAGES        = 5,
  parameter int unsigned FLUSH_HOLD_CYCLES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_STAGES-1:0]   stall_req_i,
  input  logic                    redirect_i,
  input  logic [2:0]              redirect_stage_i,
  input  logic                    csr_flush_i,
  output logic [2*NUM_STAGES-1:0] stage_ctrl_o,
  output logic                    redirect_ack_o,
  output logic                    csr_hold_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]             stall_cycles_o,
  output logic [31:0]             flush_events_o
`endif
);

  logic                  any_stall;
  logic [3:0]            stall_top;
  logic [3:0]            redir_idx;
  logic                  redirect_ok;
  logic                  csr_hold;
  logic [NUM_STAGES-1:0] stall_vec;
  logic [NUM_STAGES-1:0] flush_vec;

  csr_flush_seq #(
    .FLUSH_HOLD_CYCLES(FLUSH_HOLD_CYCLES)
  ) u_csr_flush_seq (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .csr_flush_i(csr_flush_i),
    .csr_hold_o (csr_hold)
  );

  always_comb begin
    any_stall = |stall_req_i;
    stall_top = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (stall_req_i[k]) stall_top = 4'(k);
    end
  end

  // A redirect resolving in a stalled stage waits; the source keeps it asserted.
  assign redir_idx   = {1'b0, redirect_stage_i};
  assign redirect_ok = redirect_i && (redir_idx != 4'd0) && (redir_idx < 4'(NUM_STAGES))
                       && !(any_stall && (redir_idx <= stall_top));

  always_comb begin
    stall_vec = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      stall_vec[k] = any_stall && (4'(k) <= stall_top);
    end
  end

  always_comb begin
    flush_vec = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      flush_vec[k] = ((any_stall && (4'(k) == stall_top + 4'd1))
                      || (redirect_ok && (4'(k) < redir_idx))
                      || ((k == 0) && csr_hold))
                     && !stall_vec[k];
    end
  end

  always_comb begin
    stage_ctrl_o = '0;
    if (!rst_i) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        stage_ctrl_o[2*k +: 2] = stall_vec[k] ? STALL : (flush_vec[k] ? FLUSH : RUN);
      end
    end
  end

  assign redirect_ack_o = redirect_ok && !rst_i;
  assign csr_hold_o     = csr_hold;

`ifdef HAZARD_PERF_CNT_EN
  logic        csr_prev;
  logic [1:0]  flush_inc;
  logic [32:0] flush_sum;

  assign flush_inc = {1'b0, redirect_ok} + {1'b0, csr_flush_i & ~csr_prev};
  assign flush_sum = {1'b0, flush_events_o} + 33'(flush_inc);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csr_prev       <= 1'b0;
      stall_cycles_o <= '0;
      flush_events_o <= '0;
    end else begin
      csr_prev <= csr_flush_i;
      if (any_stall && (stall_cycles_o != '1)) stall_cycles_o <= stall_cycles_o + 32'd1;
      flush_events_o <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed-vector bench for pipeline_hazard_ctrl (5 stages, hold 2; plus a 2-stage, hold-0 instance). Rev 1.0
`default_nettype none

module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] stall;
  logic       redir;
  logic [2:0] rstage;
  logic       csr;

  logic [9:0] ctrl;
  logic       ack;
  logic       hold;
  logic [3:0] ctrl0;
  logic       ack0;
  logic       hold0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc, fe, sc0, fe0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .NUM_STAGES(5),
    .FLUSH_HOLD_CYCLES(2)
  ) u_dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_req_i     (stall),
    .redirect_i      (redir),
    .redirect_stage_i(rstage),
    .csr_flush_i     (csr),
    .stage_ctrl_o    (ctrl),
    .redirect_ack_o  (ack),
    .csr_hold_o      (hold)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles_o  (sc),
    .flush_events_o  (fe)
`endif
  );

  pipeline_hazard_ctrl #(
    .NUM_STAGES(2),
    .FLUSH_HOLD_CYCLES(0)
  ) u_dut0 (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_req_i     (2'b00),
    .redirect_i      (1'b0),
    .redirect_stage_i(3'd1),
    .csr_flush_i     (csr),
    .stage_ctrl_o    (ctrl0),
    .redirect_ack_o  (ack0),
    .csr_hold_o      (hold0)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles_o  (sc0),
    .flush_events_o  (fe0)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change just after the falling edge; outputs are sampled 2 ns later, well before the rising edge.
  task automatic drive(input logic r, input logic [4:0] s, input logic rd,
                       input logic [2:0] rs, input logic c);
    @(negedge clk);
    rst = r; stall = s; redir = rd; rstage = rs; csr = c;
    #2;
  endtask

  initial begin
    logic pulse_pat [6];
    logic hold_exp  [6];
    pulse_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    hold_exp  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rst = 1'b1; stall = '0; redir = 1'b0; rstage = '0; csr = 1'b0;

    drive(1, 5'b00100, 1, 3'd2, 1);
    check("reset_ctrl", 32'(ctrl), 32'h0);
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_hold", 32'(hold), 32'h0);
    check("reset_hold0", 32'(hold0), 32'h0);

    drive(0, 5'b00000, 0, 3'd0, 0);
    check("idle_ctrl", 32'(ctrl), 32'h0);
    check("idle_hold", 32'(hold), 32'h0);

    drive(0, 5'b00100, 0, 3'd0, 0);
    check("stall2_ctrl", 32'(ctrl), 32'(10'b0010010101));
    drive(0, 5'b00001, 0, 3'd0, 0);
    check("stall0_ctrl", 32'(ctrl), 32'(10'b0000001001));
    drive(0, 5'b10000, 0, 3'd0, 0);
    check("stall4_ctrl", 32'(ctrl), 32'(10'b0101010101));
    drive(0, 5'b10001, 0, 3'd0, 0);
    check("stall40_ctrl", 32'(ctrl), 32'(10'b0101010101));

    drive(0, 5'b00000, 1, 3'd2, 0);
    check("redir2_ack", 32'(ack), 32'h1);
    check("redir2_ctrl", 32'(ctrl), 32'(10'b0000001010));

    for (int i = 0; i < 3; i++) begin
      drive(0, 5'b01000, 1, 3'd2, 0);
      check("redir_stalled_ack", 32'(ack), 32'h0);
      check("redir_stalled_ctrl", 32'(ctrl), 32'(10'b1001010101));
    end
    drive(0, 5'b00000, 1, 3'd2, 0);
    check("redir_release_ack", 32'(ack), 32'h1);
    check("redir_release_ctrl", 32'(ctrl), 32'(10'b0000001010));

    drive(0, 5'b00001, 1, 3'd4, 0);
    check("redir4_stall0_ack", 32'(ack), 32'h1);
    check("redir4_stall0_ctrl", 32'(ctrl), 32'(10'b0010101001));
    drive(0, 5'b00001, 1, 3'd1, 0);
    check("redir1_stall0_ack", 32'(ack), 32'h1);
    check("redir1_stall0_ctrl", 32'(ctrl), 32'(10'b0000001001));

    drive(0, 5'b00000, 0, 3'd0, 0);
    drive(0, 5'b00000, 0, 3'd0, 1);
    check("csr_c0_hold", 32'(hold), 32'h1);
    check("csr_c0_ctrl", 32'(ctrl), 32'(10'b0000000010));
    check("csr_c0_hold0", 32'(hold0), 32'h1);
    check("csr_c0_ctrl0", 32'(ctrl0), 32'(4'b0010));
    drive(0, 5'b00000, 0, 3'd0, 0);
    check("csr_c1_hold", 32'(hold), 32'h1);
    check("csr_c1_hold0", 32'(hold0), 32'h0);
    check("csr_c1_ctrl0", 32'(ctrl0), 32'h0);
    drive(0, 5'b00001, 0, 3'd0, 0);
    check("csr_c2_hold", 32'(hold), 32'h1);
    check("csr_c2_stall_ctrl", 32'(ctrl), 32'(10'b0000001001));
    drive(0, 5'b00000, 0, 3'd0, 0);
    check("csr_c3_hold", 32'(hold), 32'h0);
    check("csr_c3_ctrl", 32'(ctrl), 32'h0);

    for (int i = 0; i < 6; i++) begin
      drive(0, 5'b00000, 0, 3'd0, pulse_pat[i]);
      check($sformatf("csr_restart_c%0d", i), 32'(hold), 32'(hold_exp[i]));
    end

    drive(0, 5'b00000, 1, 3'd3, 1);
    check("union_ack", 32'(ack), 32'h1);
    check("union_hold", 32'(hold), 32'h1);
    check("union_ctrl", 32'(ctrl), 32'(10'b0000101010));
    repeat (3) drive(0, 5'b00000, 0, 3'd0, 0);

    drive(0, 5'b00000, 0, 3'd0, 1);
    drive(1, 5'b00100, 1, 3'd2, 1);
    check("rst_mid_ctrl", 32'(ctrl), 32'h0);
    check("rst_mid_ack", 32'(ack), 32'h0);
    check("rst_mid_hold", 32'(hold), 32'h0);
    drive(0, 5'b00000, 0, 3'd0, 0);
    check("rst_after_hold", 32'(hold), 32'h0);
    check("rst_after_ctrl", 32'(ctrl), 32'h0);

`ifdef HAZARD_PERF_CNT_EN
    drive(1, 5'b00000, 0, 3'd0, 0);
    check("perf_reset_sc", sc, 32'd0);
    check("perf_reset_fe", fe, 32'd0);
    repeat (10) drive(0, 5'b00001, 0, 3'd0, 0);
    repeat (2) drive(0, 5'b00000, 1, 3'd2, 0);
    drive(0, 5'b00000, 0, 3'd0, 0);
    check("perf_stall_cycles", sc, 32'd10);
    check("perf_flush_events", fe, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
